// File: rtl/display_pkg.sv
// display_pkg: shared constants and hex-to-7-segment decode for the display multiplexer
package display_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  function automatic logic [0:6] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0001100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction
endpackage

// File: rtl/display_mux_if.sv
// display_mux_if: data/strobe inputs and segment/anode outputs of the display multiplexer
interface display_mux_if import display_pkg::*; #(parameter int N_DIGITS = 4);
  logic [DIGIT_W*N_DIGITS-1:0] entrada;
  logic [N_DIGITS-1:0] pontos;
  logic carregar;
  logic apagaZeros;
  logic [0:6] saida;
  logic ponto;
  logic [N_DIGITS-1:0] anodo;
  modport master(output entrada, pontos, carregar, apagaZeros, input saida, ponto, anodo);
  modport slave(input entrada, pontos, carregar, apagaZeros, output saida, ponto, anodo);
endinterface

// File: rtl/display_prescaler.sv
// display_prescaler: free-running 0..DIV-1 slot counter exposing its next value and wrap tick
module display_prescaler #(
  parameter int DIV = 50000,
  localparam int CW = $clog2(DIV)
) (
  input  logic clk,
  input  logic rst,
  output logic [CW-1:0] nxt,
  output logic tick
);
  logic [CW-1:0] count;
  assign tick = count == CW'(DIV - 1);
  assign nxt = tick ? '0 : count + 1'b1;
  // advance the slot counter, wrapping at DIV-1
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else count <= nxt;
endmodule

// File: rtl/display_mux.sv
// display_mux: round-robin 7-segment scanner with anti-ghost blanking, zero suppression and decimal points
module display_mux import display_pkg::*; #(
  parameter int N_DIGITS = 4,
  parameter int DIV = 50000,
  parameter int BLANK_CYC = 1
) (
  input logic clockDisplay,
  input logic reset,
  display_mux_if.slave bus
);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam int CW = $clog2(DIV);
  logic [DIGIT_W*N_DIGITS-1:0] buffer;
  logic [N_DIGITS-1:0] dp, sup;
  logic [IW-1:0] idx, idx_nx;
  logic [CW-1:0] cnt_nx;
  logic [DIGIT_W-1:0] dig;
  logic tick, lit, hi;
  display_prescaler #(.DIV(DIV)) u_pre (
    .clk(clockDisplay),
    .rst(reset),
    .nxt(cnt_nx),
    .tick(tick)
  );
  assign idx_nx = tick ? (idx == IW'(N_DIGITS - 1) ? '0 : idx + 1'b1) : idx;
  assign dig = buffer[idx_nx*DIGIT_W +: DIGIT_W];
  assign lit = cnt_nx >= CW'(BLANK_CYC);
  // a digit is blanked when it and every more significant digit are zero; digit 0 always shows
  always_comb begin
    hi = 1'b1;
    sup = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      hi = hi && buffer[k*DIGIT_W +: DIGIT_W] == '0;
      sup[k] = bus.apagaZeros && hi && k != 0;
    end
  end
  // latch display data and register outputs from the post-edge slot position
  always_ff @(posedge clockDisplay)
    if (reset) begin
      buffer <= '0;
      dp <= '0;
      idx <= '0;
      bus.anodo <= '1;
      bus.saida <= SEG_BLANK;
      bus.ponto <= 1'b1;
    end else begin
      if (bus.carregar) begin
        buffer <= bus.entrada;
        dp <= bus.pontos;
      end
      idx <= idx_nx;
      bus.anodo <= lit ? ~(N_DIGITS'(1) << idx_nx) : '1;
      bus.saida <= !lit || sup[idx_nx] ? SEG_BLANK : hex_to_seg(dig);
      bus.ponto <= !lit || !dp[idx_nx];
    end
endmodule

// File: tb/tb_display_mux.sv
// tb_display_mux: random stimulus against a slot-arithmetic reference model for two display_mux configurations
module tb_display_mux;
  logic clk = 0;
  logic rst;
  logic [15:0] ent;
  logic [3:0] pts;
  logic ld, apz;
  int checks = 0;
  int fails = 0;
  int n = 0;
  logic chk_en = 0;
  logic [15:0] mbuf;
  logic [3:0] mdp;
  logic [11:0] ea, eb;
  logic [6:0] seg_tab [16];

  always #5 clk = ~clk;

  display_mux_if #(.N_DIGITS(4)) ifa ();
  display_mux_if #(.N_DIGITS(4)) ifb ();
  assign ifa.entrada = ent;
  assign ifa.pontos = pts;
  assign ifa.carregar = ld;
  assign ifa.apagaZeros = apz;
  assign ifb.entrada = ent;
  assign ifb.pontos = pts;
  assign ifb.carregar = ld;
  assign ifb.apagaZeros = apz;

  display_mux #(.N_DIGITS(4), .DIV(4), .BLANK_CYC(1)) dut_a (.clockDisplay(clk), .reset(rst), .bus(ifa));
  display_mux #(.N_DIGITS(4), .DIV(2), .BLANK_CYC(0)) dut_b (.clockDisplay(clk), .reset(rst), .bus(ifb));

  initial begin
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  end

  // n edges after reset: slot position is n mod DIV, digit is (n div DIV) mod 4
  function automatic logic [11:0] model(int cyc, int div, int blank, logic [15:0] b, logic [3:0] d, logic z);
    int p = cyc % div;
    int k = (cyc / div) % 4;
    logic [15:0] upper = b >> (4 * k);
    logic [3:0] one = 4'b0001 << k;
    if (p < blank) return {4'hF, 7'h7F, 1'b1};
    return {~one, (z && k > 0 && upper == 16'h0) ? 7'h7F : seg_tab[upper[3:0]], ~d[k]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h want %h at n=%0d", nm, got, exp, n);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      n = 0;
      mbuf = '0;
      mdp = '0;
      ea = {4'hF, 7'h7F, 1'b1};
      eb = {4'hF, 7'h7F, 1'b1};
      chk_en = 1;
    end else begin
      n++;
      ea = model(n, 4, 1, mbuf, mdp, apz);
      eb = model(n, 2, 0, mbuf, mdp, apz);
      if (ld) begin
        mbuf = ent;
        mdp = pts;
      end
    end
  end

  always @(negedge clk)
    if (chk_en) begin
      chk("dut_a", {ifa.anodo, ifa.saida, ifa.ponto}, ea);
      chk("dut_b", {ifb.anodo, ifb.saida, ifb.ponto}, eb);
      chk("onehot_a", $countones(~ifa.anodo) <= 1, 1);
      chk("onehot_b", $countones(~ifb.anodo) <= 1, 1);
    end

  initial begin
    logic [15:0] picks [4];
    picks = '{16'h0030, 16'h0000, 16'h0005, 16'h12AF};
    rst = 1; ld = 0; ent = '0; pts = '0; apz = 0;
    repeat (3) @(negedge clk);
    chk("pin_reset", {ifa.anodo, ifa.saida, ifa.ponto}, {4'b1111, 7'b1111111, 1'b1});
    rst = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("pin_first_a", {ifa.anodo, ifa.saida}, {4'b1110, 7'b0000001});
        chk("pin_first_b", {ifb.anodo, ifb.saida}, {4'b1110, 7'b0000001});
        ld = 1; ent = 16'h12AF; pts = 4'b0000;
      end
      if (i == 2) ld = 0;
      if (i == 3) begin
        chk("pin_F", {ifa.anodo, ifa.saida}, {4'b1110, 7'b0111000});
        chk("pin_b_A", {ifb.anodo, ifb.saida}, {4'b1101, 7'b0001000});
      end
      if (i == 4) chk("pin_blank", {ifa.anodo, ifa.saida, ifa.ponto}, {4'b1111, 7'b1111111, 1'b1});
      if (i == 5) chk("pin_A", {ifa.anodo, ifa.saida}, {4'b1101, 7'b0001000});
      if (i == 9) chk("pin_2", {ifa.anodo, ifa.saida}, {4'b1011, 7'b0010010});
      if (i == 13) chk("pin_1", {ifa.anodo, ifa.saida}, {4'b0111, 7'b1001111});
    end
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = $urandom_range(399) == 0 || (rst && $urandom_range(1) == 0);
      ld = $urandom_range(5) == 0;
      if ($urandom_range(3) == 0) ent = picks[$urandom_range(3)];
      else for (int k = 0; k < 4; k++) ent[k*4 +: 4] = $urandom_range(1) ? 4'h0 : 4'($urandom);
      pts = 4'($urandom);
      if ($urandom_range(19) == 0) apz = ~apz;
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
